aes_round_sequencer: RTL and testbench
======================================

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter NR, default 10, SHALL set the number of AES rounds; legal values 10, 12, 14.
REQ-002 Parameter PIPE_LAT, default 2, SHALL set the datapath output latency in cycles, from sequencer OUT-state entry to the first valid ciphertext byte; legal range 0..4.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request a block; sampled only in IDLE.
REQ-006 abort  in  1  synchronous cancel of the current block.
REQ-007 in_ready  out  1  high when IDLE, meaning start will be accepted.
REQ-008 busy  out  1  high in any state except IDLE.
REQ-009 done  out  1  one-cycle pulse at block completion.
REQ-010 out_valid, out_last  out  1 each  ciphertext byte strobe and 16th-byte marker.
REQ-011 input_sel, sbox_sel, last_out_sel, bit_out_sel  out  1 each  key-schedule mux selects.
REQ-012 rcon_en  out  1 and rcon  out  8  round-constant enable and round-constant value.
REQ-013 mc_en, pld  out  1 each  MixColumns enable and parallel load.
REQ-014 c3  out  2  ShiftRows select.
REQ-015 round  out  4  current round, 0 in IDLE and LOAD, otherwise 1..NR.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD(16), B1ST(1), B2ND(2), B3RD(1), NORM(8), SHIF(4) and OUT(16); bracketed figures are dwell cycles.
REQ-017 Transitions SHALL be IDLE->LOAD on start, LOAD->B1ST, then B1ST->B2ND->B3RD->NORM->SHIF, and SHIF->B1ST while round<NR, else SHIF->OUT, then OUT->IDLE.
REQ-018 Each round SHALL last exactly 16 cycles; byte_idx 0..15 counts within LOAD, each round and OUT, and wraps to 0 on every state-group change.
REQ-019 round SHALL increment on LOAD->B1ST and on each SHIF->B1ST transition.
REQ-020 Mux selects as {input_sel, sbox_sel, last_out_sel, bit_out_sel} SHALL be: LOAD/IDLE/OUT 0100, B1ST 1101, B2ND 1101, B3RD 1001, NORM 1011, SHIF 1010.
REQ-021 rcon_en SHALL be high only in B1ST.
REQ-022 rcon SHALL be 0x01 in round 1 and xtime(previous) on each round increment (0x1B after 0x80); it resets to 0x01 on LOAD entry.
REQ-023 c3 SHALL be registered and equal 3 in IDLE and LOAD; otherwise it takes, by byte_idx 0..15, the values 2,1,0,3,2,1,1,3,2,3,2,3,3,3,3,3.
REQ-024 pld SHALL be registered and high when byte_idx[1:0]==3 in B1ST..SHIF; it is low elsewhere.
REQ-025 mc_en SHALL be registered and low when byte_idx[1:0]==3, or throughout round NR (the final round has no MixColumns); it is high otherwise.
REQ-026 out_valid SHALL be high for exactly 16 consecutive cycles, starting PIPE_LAT cycles after OUT entry; out_last SHALL be high on the 16th.
REQ-027 done SHALL pulse in the cycle after out_last; done may coincide with IDLE and in_ready.
REQ-028 Total latency SHALL be 16 + 16*NR + 16 + PIPE_LAT + 1 cycles from the start-accept edge to done.
REQ-029 start while busy SHALL be ignored, with no queueing.
REQ-030 On abort in any non-IDLE state, the FSM SHALL return to IDLE on the next edge, clear the pipeline valid shift register and suppress done; if abort and start arrive in the same cycle in IDLE, start wins.

Reset
REQ-031 rst SHALL force IDLE, byte_idx=0, round=0 and rcon=0x01.
REQ-032 rst SHALL force out_valid, out_last, done, busy, pld, mc_en and rcon_en to 0, c3 to 3, and in_ready to 1.
REQ-033 Reset asserted mid-block SHALL discard the block with no done; after release, the first start behaves as from power-up.

Structure
REQ-034 Package aes_seq_pkg SHALL hold the state enum, the dwell-length constants, the 16-entry c3 table, the xtime function and the NR legality check.
REQ-035 Sub-module aes_rcon_gen (8-bit register with xtime update, load and advance inputs) SHALL produce rcon.
REQ-036 Parameter legality SHALL be checked at elaboration; an illegal NR is an elaboration error.

Verification
REQ-037 NR=10, PIPE_LAT=2, one start: done at cycle 195; rcon sequence 01,02,04,08,10,20,40,80,1B,36; 16 out_valid; out_last on the 16th.
REQ-038 NR=14: done at cycle 259; mc_en low across all of round 14; rcon reaches 0x4D in round 14.
REQ-039 start held high continuously: a new block starts the cycle after done, and no start is accepted while busy.
REQ-040 abort in NORM of round 5: IDLE next cycle, no out_valid and no done; the next start begins with rcon=0x01 and round=1.
REQ-041 rst asserted at LOAD byte_idx 7: all outputs return to reset values immediately (asynchronously); the next block matches the REQ-037 trace.
REQ-042 PIPE_LAT=0: out_valid is coincident with OUT entry and done arrives at cycle 193.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared types and constants for the AES round sequencer.
//   - seq_state_e : sequencer states
//   - *_LEN/*_END : dwell lengths and last byte_idx of each state
//   - C3_TAB      : ShiftRows select by byte_idx
//   - xtime       : GF(2^8) multiply-by-2 for the round constant
//   - nr_legal    : legal round counts
//   - mux_sel     : key-schedule mux selects per state
package aes_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_B1ST, S_B2ND, S_B3RD, S_NORM, S_SHIF, S_OUT
  } seq_state_e;

  localparam int LOAD_LEN  = 16;
  localparam int B1ST_LEN  = 1;
  localparam int B2ND_LEN  = 2;
  localparam int B3RD_LEN  = 1;
  localparam int NORM_LEN  = 8;
  localparam int SHIF_LEN  = 4;
  localparam int OUT_LEN   = 16;
  localparam int ROUND_LEN = B1ST_LEN + B2ND_LEN + B3RD_LEN + NORM_LEN + SHIF_LEN;

  // byte_idx runs continuously through a round, so each sub-state ends at
  // the cumulative dwell count minus one.
  localparam logic [3:0] LOAD_END = 4'(LOAD_LEN - 1);
  localparam logic [3:0] B1ST_END = 4'(B1ST_LEN - 1);
  localparam logic [3:0] B2ND_END = 4'(B1ST_LEN + B2ND_LEN - 1);
  localparam logic [3:0] B3RD_END = 4'(B1ST_LEN + B2ND_LEN + B3RD_LEN - 1);
  localparam logic [3:0] NORM_END = 4'(B1ST_LEN + B2ND_LEN + B3RD_LEN + NORM_LEN - 1);
  localparam logic [3:0] SHIF_END = 4'(ROUND_LEN - 1);
  localparam logic [3:0] OUT_END  = 4'(OUT_LEN - 1);

  localparam logic [1:0] C3_TAB [0:15] = '{
    2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd1, 2'd3,
    2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3
  };

  typedef struct packed {
    logic input_sel;
    logic sbox_sel;
    logic last_out_sel;
    logic bit_out_sel;
  } mux_sel_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic bit nr_legal(input int nr);
    return (nr == 10) || (nr == 12) || (nr == 14);
  endfunction

  function automatic logic is_round(input seq_state_e s);
    return (s == S_B1ST) || (s == S_B2ND) || (s == S_B3RD) ||
           (s == S_NORM) || (s == S_SHIF);
  endfunction

  function automatic mux_sel_t mux_sel(input seq_state_e s);
    case (s)
      S_B1ST, S_B2ND: return mux_sel_t'(4'b1101);
      S_B3RD:         return mux_sel_t'(4'b1001);
      S_NORM:         return mux_sel_t'(4'b1011);
      S_SHIF:         return mux_sel_t'(4'b1010);
      default:        return mux_sel_t'(4'b0100);
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: control bus of the round sequencer.
//   master: drives start/abort, observes status and datapath controls
//   slave : the sequencer
interface aes_round_sequencer_if;
  logic       start, abort;
  logic       in_ready, busy, done;
  logic       out_valid, out_last;
  logic       input_sel, sbox_sel, last_out_sel, bit_out_sel;
  logic       rcon_en;
  logic [7:0] rcon;
  logic       mc_en, pld;
  logic [1:0] c3;
  logic [3:0] round;

  modport master (
    output start, abort,
    input  in_ready, busy, done, out_valid, out_last,
           input_sel, sbox_sel, last_out_sel, bit_out_sel,
           rcon_en, rcon, mc_en, pld, c3, round
  );

  modport slave (
    input  start, abort,
    output in_ready, busy, done, out_valid, out_last,
           input_sel, sbox_sel, last_out_sel, bit_out_sel,
           rcon_en, rcon, mc_en, pld, c3, round
  );
endinterface

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: AES round-constant register.
//   clk, rst : clock, async active-high reset (rcon -> 0x01)
//   load     : reload 0x01 (new block)
//   advance  : rcon <= xtime(rcon) (next round)
//   rcon     : current round constant
module aes_rcon_gen
  import aes_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] rcon
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rcon <= 8'h01;
    else if (load)    rcon <= 8'h01;
    else if (advance) rcon <= xtime(rcon);
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: byte-serial AES encryption control sequencer.
//   Parameters: NR (10/12/14 rounds), PIPE_LAT (0..4 datapath output latency)
//   clk, rst : clock, async active-high reset
//   bus      : aes_round_sequencer_if.slave -- start/abort in; status,
//              ciphertext strobes and datapath mux/enable controls out.
// A block is LOAD (16) + NR rounds of 16 + OUT (16); the output strobes are
// the OUT-state strobe delayed PIPE_LAT cycles through vld_pipe/last_pipe.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NR       = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.slave  bus
);

  if (!nr_legal(NR)) begin : g_bad_nr
    $fatal(1, "aes_round_sequencer: NR must be 10, 12 or 14");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_lat
    $fatal(1, "aes_round_sequencer: PIPE_LAT must be 0..4");
  end

  localparam logic [3:0] NR_W = 4'(NR);

  seq_state_e          state, state_nx;
  logic [3:0]          byte_idx, byte_nx;
  logic [3:0]          round_q, round_nx;
  logic [1:0]          c3_q;
  logic                pld_q, mc_en_q, done_q;
  logic [PIPE_LAT:0]   vld_pipe, last_pipe;
  logic                in_ready, accept, kill;
  logic [7:0]          rcon;
  mux_sel_t            sel;

  // New blocks wait for the previous block's output strobes to drain, so a
  // held start launches the next block right after done.
  assign in_ready = (state == S_IDLE) && !(|vld_pipe);
  assign accept   = in_ready && bus.start;
  assign kill     = bus.abort && (state != S_IDLE);

  always_comb begin
    state_nx = state;
    round_nx = round_q;
    byte_nx  = byte_idx + 4'd1;  // every state group is 16 long: wraps to 0
    case (state)
      S_IDLE: begin
        byte_nx  = '0;
        round_nx = '0;
        if (accept) state_nx = S_LOAD;
      end
      S_LOAD: if (byte_idx == LOAD_END) begin
        state_nx = S_B1ST;
        round_nx = 4'd1;
      end
      S_B1ST: if (byte_idx == B1ST_END) state_nx = S_B2ND;
      S_B2ND: if (byte_idx == B2ND_END) state_nx = S_B3RD;
      S_B3RD: if (byte_idx == B3RD_END) state_nx = S_NORM;
      S_NORM: if (byte_idx == NORM_END) state_nx = S_SHIF;
      S_SHIF: if (byte_idx == SHIF_END) begin
        if (round_q < NR_W) begin
          state_nx = S_B1ST;
          round_nx = round_q + 4'd1;
        end else begin
          state_nx = S_OUT;
        end
      end
      S_OUT: if (byte_idx == OUT_END) begin
        state_nx = S_IDLE;
        round_nx = '0;
      end
      default: state_nx = S_IDLE;
    endcase
    if (kill) begin
      state_nx = S_IDLE;
      byte_nx  = '0;
      round_nx = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_idx  <= '0;
      round_q   <= '0;
      c3_q      <= 2'd3;
      pld_q     <= 1'b0;
      mc_en_q   <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      byte_idx <= byte_nx;
      round_q  <= round_nx;
      // Registered controls are computed from next-state so they line up
      // with the state/byte_idx they belong to.
      c3_q     <= (state_nx == S_IDLE || state_nx == S_LOAD) ? 2'd3 : C3_TAB[byte_nx];
      pld_q    <= is_round(state_nx) && (byte_nx[1:0] == 2'd3);
      // Final round has no MixColumns.
      mc_en_q  <= is_round(state_nx) && (byte_nx[1:0] != 2'd3) && (round_nx != NR_W);
      if (kill) begin
        vld_pipe  <= '0;
        last_pipe <= '0;
      end else begin
        vld_pipe[0]  <= (state_nx == S_OUT);
        last_pipe[0] <= (state_nx == S_OUT) && (byte_nx == OUT_END);
        for (int k = 1; k <= PIPE_LAT; k++) begin
          vld_pipe[k]  <= vld_pipe[k-1];
          last_pipe[k] <= last_pipe[k-1];
        end
      end
      done_q <= last_pipe[PIPE_LAT] && !kill;
    end
  end

  aes_rcon_gen u_rcon (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance ((state == S_SHIF) && (state_nx == S_B1ST)),
    .rcon    (rcon)
  );

  assign sel              = mux_sel(state);
  assign bus.in_ready     = in_ready;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = done_q;
  assign bus.out_valid    = vld_pipe[PIPE_LAT];
  assign bus.out_last     = last_pipe[PIPE_LAT];
  assign bus.input_sel    = sel.input_sel;
  assign bus.sbox_sel     = sel.sbox_sel;
  assign bus.last_out_sel = sel.last_out_sel;
  assign bus.bit_out_sel  = sel.bit_out_sel;
  assign bus.rcon_en      = (state == S_B1ST);
  assign bus.rcon         = rcon;
  assign bus.mc_en        = mc_en_q;
  assign bus.pld          = pld_q;
  assign bus.c3           = c3_q;
  assign bus.round        = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed, table-driven bench for three sequencer
// configurations (NR=10/PIPE_LAT=2, NR=14/PIPE_LAT=2, NR=10/PIPE_LAT=0).
// Cycle c of a block is the clock period after edge c-1, edge 0 being the
// start-accept edge; every cycle is captured into obs[] and checked after.
module tb_aes_round_sequencer;

  typedef struct packed {
    logic       busy;
    logic       in_ready;
    logic [3:0] round;
    logic [7:0] rcon;
    logic [3:0] sel;
    logic       rcon_en;
    logic [1:0] c3;
    logic       pld;
    logic       mc_en;
    logic       ov;
    logic       ol;
    logic       done;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  localparam int F_OV = 0, F_OL = 1, F_DONE = 2, F_MC = 3, F_BUSY = 4;
  localparam obs_t RST_OBS = {1'b0, 1'b1, 4'd0, 8'h01, 4'b0100, 1'b0, 2'd3,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_sequencer_if if10 ();
  aes_round_sequencer_if if14 ();
  aes_round_sequencer_if if0 ();

  aes_round_sequencer #(.NR(10), .PIPE_LAT(2)) u10 (.clk(clk), .rst(rst), .bus(if10));
  aes_round_sequencer #(.NR(14), .PIPE_LAT(2)) u14 (.clk(clk), .rst(rst), .bus(if14));
  aes_round_sequencer #(.NR(10), .PIPE_LAT(0)) u0  (.clk(clk), .rst(rst), .bus(if0));

  obs_t o10, o14, o0;
  assign o10 = {if10.busy, if10.in_ready, if10.round, if10.rcon, if10.input_sel, if10.sbox_sel,
                if10.last_out_sel, if10.bit_out_sel, if10.rcon_en, if10.c3, if10.pld,
                if10.mc_en, if10.out_valid, if10.out_last, if10.done};
  assign o14 = {if14.busy, if14.in_ready, if14.round, if14.rcon, if14.input_sel, if14.sbox_sel,
                if14.last_out_sel, if14.bit_out_sel, if14.rcon_en, if14.c3, if14.pld,
                if14.mc_en, if14.out_valid, if14.out_last, if14.done};
  assign o0  = {if0.busy, if0.in_ready, if0.round, if0.rcon, if0.input_sel, if0.sbox_sel,
                if0.last_out_sel, if0.bit_out_sel, if0.rcon_en, if0.c3, if0.pld,
                if0.mc_en, if0.out_valid, if0.out_last, if0.done};

  int   n_vec, n_miss;
  obs_t obs [0:449];
  vec_t tab [$];
  int   rcon_exp [0:13] = '{'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h40,
                            'h80, 'h1B, 'h36, 'h6C, 'hD8, 'hAB, 'h4D};

  function automatic vec_t mkv(int cyc, int b, int r, int rd, int rc, int s, int re,
                               int c, int p, int m, int v, int l, int d);
    vec_t x;
    x.cyc = cyc;
    x.exp = {1'(b), 1'(r), 4'(rd), 8'(rc), 4'(s), 1'(re), 2'(c), 1'(p), 1'(m),
             1'(v), 1'(l), 1'(d)};
    return x;
  endfunction

  function automatic obs_t sample(int w);
    case (w)
      1:       return o14;
      2:       return o0;
      default: return o10;
    endcase
  endfunction

  function automatic int fld(obs_t o, int f);
    case (f)
      F_OV:    return int'(o.ov);
      F_OL:    return int'(o.ol);
      F_DONE:  return int'(o.done);
      F_MC:    return int'(o.mc_en);
      default: return int'(o.busy);
    endcase
  endfunction

  function automatic int count_f(int f, int lo, int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += fld(obs[c], f);
    return n;
  endfunction

  function automatic int first_f(int f, int lo, int hi);
    for (int c = lo; c <= hi; c++) if (fld(obs[c], f) == 1) return c;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input int w, input logic s, input logic a);
    case (w)
      1:       begin if14.start = s; if14.abort = a; end
      2:       begin if0.start  = s; if0.abort  = a; end
      default: begin if10.start = s; if10.abort = a; end
    endcase
  endtask

  // Called at a negedge. start is held for cycles < start_cycles, abort is
  // raised in cycle abort_at (sampled at its closing edge).
  task automatic capture(input int w, input int ncyc, input int start_cycles,
                         input int abort_at, input bit abort_first);
    set_in(w, start_cycles > 0, abort_first);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      obs[c] = sample(w);
      set_in(w, c < start_cycles, c == abort_at);
    end
    set_in(w, 1'b0, 1'b0);
  endtask

  task automatic check_trace(input string tag);
    foreach (tab[i])
      chk_obs($sformatf("trace%s_c%0d", tag, tab[i].cyc), obs[tab[i].cyc], tab[i].exp);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    for (int w = 0; w < 3; w++) set_in(w, 1'b0, 1'b0);

    //                cyc  bsy rdy rnd rcon  sel     ren c3 pld mc ov ol dn
    tab.push_back(mkv(  1, 1, 0,  0, 'h01, 'b0100, 0, 3, 0, 0, 0, 0, 0));
    tab.push_back(mkv(  8, 1, 0,  0, 'h01, 'b0100, 0, 3, 0, 0, 0, 0, 0));
    tab.push_back(mkv( 16, 1, 0,  0, 'h01, 'b0100, 0, 3, 0, 0, 0, 0, 0));
    tab.push_back(mkv( 17, 1, 0,  1, 'h01, 'b1101, 1, 2, 0, 1, 0, 0, 0));
    tab.push_back(mkv( 18, 1, 0,  1, 'h01, 'b1101, 0, 1, 0, 1, 0, 0, 0));
    tab.push_back(mkv( 19, 1, 0,  1, 'h01, 'b1101, 0, 0, 0, 1, 0, 0, 0));
    tab.push_back(mkv( 20, 1, 0,  1, 'h01, 'b1001, 0, 3, 1, 0, 0, 0, 0));
    tab.push_back(mkv( 21, 1, 0,  1, 'h01, 'b1011, 0, 2, 0, 1, 0, 0, 0));
    tab.push_back(mkv( 23, 1, 0,  1, 'h01, 'b1011, 0, 1, 0, 1, 0, 0, 0));
    tab.push_back(mkv( 24, 1, 0,  1, 'h01, 'b1011, 0, 3, 1, 0, 0, 0, 0));
    tab.push_back(mkv( 26, 1, 0,  1, 'h01, 'b1011, 0, 3, 0, 1, 0, 0, 0));
    tab.push_back(mkv( 28, 1, 0,  1, 'h01, 'b1011, 0, 3, 1, 0, 0, 0, 0));
    tab.push_back(mkv( 29, 1, 0,  1, 'h01, 'b1010, 0, 3, 0, 1, 0, 0, 0));
    tab.push_back(mkv( 32, 1, 0,  1, 'h01, 'b1010, 0, 3, 1, 0, 0, 0, 0));
    tab.push_back(mkv( 33, 1, 0,  2, 'h02, 'b1101, 1, 2, 0, 1, 0, 0, 0));
    tab.push_back(mkv( 49, 1, 0,  3, 'h04, 'b1101, 1, 2, 0, 1, 0, 0, 0));
    tab.push_back(mkv(161, 1, 0, 10, 'h36, 'b1101, 1, 2, 0, 0, 0, 0, 0));
    tab.push_back(mkv(169, 1, 0, 10, 'h36, 'b1011, 0, 2, 0, 0, 0, 0, 0));
    tab.push_back(mkv(176, 1, 0, 10, 'h36, 'b1010, 0, 3, 1, 0, 0, 0, 0));
    tab.push_back(mkv(177, 1, 0, 10, 'h36, 'b0100, 0, 2, 0, 0, 0, 0, 0));
    tab.push_back(mkv(178, 1, 0, 10, 'h36, 'b0100, 0, 1, 0, 0, 0, 0, 0));
    tab.push_back(mkv(179, 1, 0, 10, 'h36, 'b0100, 0, 0, 0, 0, 1, 0, 0));
    tab.push_back(mkv(192, 1, 0, 10, 'h36, 'b0100, 0, 3, 0, 0, 1, 0, 0));
    tab.push_back(mkv(193, 0, 0,  0, 'h36, 'b0100, 0, 3, 0, 0, 1, 0, 0));
    tab.push_back(mkv(194, 0, 0,  0, 'h36, 'b0100, 0, 3, 0, 0, 1, 1, 0));
    tab.push_back(mkv(195, 0, 1,  0, 'h36, 'b0100, 0, 3, 0, 0, 0, 0, 1));
    tab.push_back(mkv(196, 0, 1,  0, 'h36, 'b0100, 0, 3, 0, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    chk_obs("reset_nr10", o10, RST_OBS);
    chk_obs("reset_nr14", o14, RST_OBS);
    chk_obs("reset_pl0",  o0,  RST_OBS);
    rst = 1'b0;
    @(negedge clk);

    // NR=10, PIPE_LAT=2 single block
    capture(0, 200, 1, 0, 0);
    check_trace("A");
    for (int r = 1; r <= 10; r++)
      chk($sformatf("A_rcon_r%0d", r), int'(obs[17 + 16*(r-1)].rcon), rcon_exp[r-1]);
    chk("A_ov_count",  count_f(F_OV, 1, 200), 16);
    chk("A_last_cyc",  first_f(F_OL, 1, 200), 194);
    chk("A_done_cyc",  first_f(F_DONE, 1, 200), 195);
    chk("A_done_cnt",  count_f(F_DONE, 1, 200), 1);

    // NR=14
    capture(1, 270, 1, 0, 0);
    chk("B_done_cyc",  first_f(F_DONE, 1, 270), 259);
    chk("B_mc_r14",    count_f(F_MC, 225, 240), 0);
    chk("B_mc_r13",    count_f(F_MC, 209, 224), 12);
    for (int r = 1; r <= 14; r++)
      chk($sformatf("B_rcon_r%0d", r), int'(obs[17 + 16*(r-1)].rcon), rcon_exp[r-1]);
    chk("B_ov_count",  count_f(F_OV, 1, 270), 16);

    // PIPE_LAT=0
    capture(2, 200, 1, 0, 0);
    chk("C_ov_first",  first_f(F_OV, 1, 200), 177);
    chk("C_ov_count",  count_f(F_OV, 1, 200), 16);
    chk("C_last_cyc",  first_f(F_OL, 1, 200), 192);
    chk("C_done_cyc",  first_f(F_DONE, 1, 200), 193);
    chk("C_done_idle", int'(obs[193].busy), 0);
    chk("C_done_rdy",  int'(obs[193].in_ready), 1);

    // start held continuously
    capture(0, 400, 400, 0, 0);
    chk("D_done1",      first_f(F_DONE, 1, 400), 195);
    chk("D_busy_run",   count_f(F_BUSY, 1, 192), 192);
    chk("D_busy_gap",   count_f(F_BUSY, 193, 195), 0);
    chk("D_restart",    int'(obs[196].busy), 1);
    chk("D_rdy_busy",   int'(obs[100].in_ready), 0);
    chk("D_done2",      first_f(F_DONE, 196, 400), 390);
    chk("D_busy_total", count_f(F_BUSY, 1, 400), 192 + 192 + 10);
    set_in(0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(0, 1'b0, 1'b0);
    chk("D_abort_load", int'(o10.busy), 0);
    repeat (3) @(negedge clk);

    // abort in NORM of round 5 (cycles 85..92)
    capture(0, 120, 1, 88, 0);
    chk("E_pre_sel",   int'(obs[88].sel), 'hB);
    chk("E_pre_round", int'(obs[88].round), 5);
    chk("E_idle",      int'(obs[89].busy), 0);
    chk("E_rdy",       int'(obs[89].in_ready), 1);
    chk("E_round0",    int'(obs[89].round), 0);
    chk("E_no_ov",     count_f(F_OV, 1, 120), 0);
    chk("E_no_done",   count_f(F_DONE, 1, 120), 0);
    // start and abort together in IDLE: start wins
    capture(0, 200, 1, 0, 1);
    chk("E2_accept",   int'(obs[1].busy), 1);
    chk("E2_rcon_ld",  int'(obs[1].rcon), 'h01);
    chk("E2_round1",   int'(obs[17].round), 1);
    chk("E2_rcon_r1",  int'(obs[17].rcon), 'h01);
    chk("E2_done_cyc", first_f(F_DONE, 1, 200), 195);

    // reset at LOAD byte_idx 7
    capture(0, 8, 1, 0, 0);
    chk("F_in_load", int'(obs[8].busy), 1);
    #2 rst = 1'b1;
    #1 chk_obs("F_async_reset", o10, RST_OBS);
    @(negedge clk);
    chk_obs("F_held_reset", o10, RST_OBS);
    rst = 1'b0;
    @(negedge clk);
    capture(0, 200, 1, 0, 0);
    check_trace("F");
    chk("F_done_cyc", first_f(F_DONE, 1, 200), 195);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
